// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 3-flop synchronized line, 2-of-3 majority bit sampling,
// optional parity, 1 or 2 stop bits, break handling via WAIT_HI.
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sclk_50M,
    input  logic                 s_rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 done_flag,
    output logic                 parity_err,
    output logic                 frame_err
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BAUD_M   = BAUD_DIV / 2 - 1;
    localparam int CW       = $clog2(BAUD_DIV);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
            PARITY < 0 || PARITY > 2 || BAUD_DIV < 8) begin : g_bad_cfg
            $error("uart_rx_cfg: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HI} state_t;
    state_t state, state_nxt;

    logic [2:0]           sync;
    logic                 rx_s, rx_prev, fall;
    logic [CW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic                 samp_a, samp_b, maj;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad, stop_bad, frame_bad;
    logic                 at_dec, at_wrap, last_data, last_stop;
    logic                 shift_en, par_en, stop_en, finish;

    assign rx_s      = sync[2];
    assign fall      = rx_prev & ~rx_s;
    assign at_dec    = (baud_cnt == CW'(BAUD_M + 1));
    assign at_wrap   = (baud_cnt == CW'(BAUD_DIV - 1));
    assign maj       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
    assign last_stop = (bit_cnt == 4'(STOP_BITS - 1));
    assign frame_bad = stop_bad | ~maj;

    always_ff @(posedge sclk_50M) begin
        if (s_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fall) state_nxt = START;
            START: begin
                if (at_dec && maj)  state_nxt = IDLE;
                else if (at_wrap)   state_nxt = DATA;
            end
            DATA:    if (at_wrap && last_data) state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:     if (at_wrap) state_nxt = STOP;
            // Leave at the last stop-bit decision so a start edge in its second half is caught
            STOP:    if (at_dec && last_stop) state_nxt = frame_bad ? WAIT_HI : IDLE;
            WAIT_HI: if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        finish   = 1'b0;
        case (state)
            DATA: shift_en = at_dec;
            PAR:  par_en   = at_dec;
            STOP: begin
                stop_en = at_dec;
                finish  = at_dec & last_stop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sclk_50M) begin
        if (s_rst) begin
            sync       <= '1;
            rx_prev    <= 1'b1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            samp_a     <= 1'b0;
            samp_b     <= 1'b0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            rx_data    <= '0;
            done_flag  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync    <= {sync[1:0], rx};
            rx_prev <= rx_s;

            // Held at zero while idle so START always begins from count 0
            if (state == IDLE || state == WAIT_HI) baud_cnt <= '0;
            else if (at_wrap)                     baud_cnt <= '0;
            else                                  baud_cnt <= baud_cnt + 1'b1;

            if (baud_cnt == CW'(BAUD_M - 1)) samp_a <= rx_s;
            if (baud_cnt == CW'(BAUD_M))     samp_b <= rx_s;

            if (state != DATA && state != STOP)  bit_cnt <= '0;
            else if (at_wrap) begin
                if (state == DATA && last_data)  bit_cnt <= '0;
                else                             bit_cnt <= bit_cnt + 1'b1;
            end

            if (shift_en) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (par_en)   par_bad <= (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);

            if (state == START)        stop_bad <= 1'b0;
            else if (stop_en && !maj)  stop_bad <= 1'b1;

            done_flag <= finish;
            if (finish) begin
                rx_data    <= shreg;
                parity_err <= par_bad;
                frame_err  <= frame_bad;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) at 16 clocks per bit,
// sharing one driven line routed to the selected instance.
module tb_uart_rx_cfg;
    localparam int BIT_T = 16;

    logic sclk_50M = 1'b0;
    always #5 sclk_50M = ~sclk_50M;

    logic s_rst, rx;
    int   sel;
    logic rx_a, rx_b, rx_c;
    logic [7:0] data_a, data_b, data_c;
    logic done_a, done_b, done_c, perr_a, perr_b, perr_c, ferr_a, ferr_b, ferr_c;

    assign rx_a = (sel == 0) ? rx : 1'b1;
    assign rx_b = (sel == 1) ? rx : 1'b1;
    assign rx_c = (sel == 2) ? rx : 1'b1;

    uart_rx_cfg #(.CLK_FREQ(1600), .BAUD(100)) u_8n1 (
        .sclk_50M(sclk_50M), .s_rst(s_rst), .rx(rx_a), .rx_data(data_a),
        .done_flag(done_a), .parity_err(perr_a), .frame_err(ferr_a));
    uart_rx_cfg #(.CLK_FREQ(1600), .BAUD(100), .PARITY(2)) u_8e1 (
        .sclk_50M(sclk_50M), .s_rst(s_rst), .rx(rx_b), .rx_data(data_b),
        .done_flag(done_b), .parity_err(perr_b), .frame_err(ferr_b));
    uart_rx_cfg #(.CLK_FREQ(1600), .BAUD(100), .STOP_BITS(2)) u_8n2 (
        .sclk_50M(sclk_50M), .s_rst(s_rst), .rx(rx_c), .rx_data(data_c),
        .done_flag(done_c), .parity_err(perr_c), .frame_err(ferr_c));

    int n_vec = 0, n_err = 0;
    int cyc = 0, stop_cyc = 0, done_cyc_a = 0;
    int done_cnt_a = 0, done_cnt_b = 0, done_cnt_c = 0;
    int c_cyc[4];
    logic [7:0] c_data[4];

    always @(posedge sclk_50M) cyc <= cyc + 1;

    always @(negedge sclk_50M) begin
        if (done_a) begin
            done_cnt_a++;
            done_cyc_a = cyc;
        end
        if (done_b) done_cnt_b++;
        if (done_c) begin
            if (done_cnt_c < 4) begin
                c_cyc[done_cnt_c]  = cyc;
                c_data[done_cnt_c] = data_c;
            end
            done_cnt_c++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic spike, input logic do_rst);
        rx = b;
        for (int i = 0; i < BIT_T; i++) begin
            if (spike && i == 8)  rx = 1'b0;
            if (spike && i == 9)  rx = b;
            if (do_rst && i == 8)  s_rst = 1'b1;
            if (do_rst && i == 10) s_rst = 1'b0;
            @(negedge sclk_50M);
        end
    endtask

    task automatic send_frame(input logic [8:0] d, input int nbits, input int par,
                              input int nstop, input int spike_bit, input int rst_bit);
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(d[i], i == spike_bit, i == rst_bit);
        if (par >= 0) send_bit(par[0], 1'b0, 1'b0);
        for (int i = 0; i < nstop; i++) begin
            if (i == nstop - 1) stop_cyc = cyc;
            send_bit(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge sclk_50M);
    endtask

    initial begin
        int lat;
        s_rst = 1'b1;
        rx    = 1'b1;
        sel   = 0;
        repeat (3) @(negedge sclk_50M);
        check_val("rst_data_a", data_a, 8'h00);
        check_val("rst_done_a", done_a, 1'b0);
        check_val("rst_perr_a", perr_a, 1'b0);
        check_val("rst_ferr_a", ferr_a, 1'b0);
        check_val("rst_data_b", data_b, 8'h00);
        check_val("rst_done_c", done_c, 1'b0);
        s_rst = 1'b0;
        idle(20);

        // 8N1 0xA5
        send_frame(9'h0A5, 8, -1, 1, -1, -1);
        idle(20);
        check_val("a5_done_cnt", done_cnt_a, 1);
        check_val("a5_data", data_a, 8'hA5);
        check_val("a5_perr", perr_a, 1'b0);
        check_val("a5_ferr", ferr_a, 1'b0);
        lat = done_cyc_a - stop_cyc;
        check_val("a5_done_latency_in_window", (lat >= 8 && lat <= 20), 1'b1);

        // Idle-line glitch must be rejected
        rx = 1'b0;
        repeat (4) @(negedge sclk_50M);
        idle(40);
        check_val("glitch_done_cnt", done_cnt_a, 1);
        check_val("glitch_data_kept", data_a, 8'hA5);
        check_val("glitch_ferr_kept", ferr_a, 1'b0);

        // One-cycle low spike at the centre of data bit 2 (a 1) is outvoted
        send_frame(9'h00F, 8, -1, 1, 2, -1);
        idle(20);
        check_val("spike_done_cnt", done_cnt_a, 2);
        check_val("spike_data", data_a, 8'h0F);

        // Even parity: 0x03 has even weight, so parity bit 1 is wrong, 0 is right
        sel = 1;
        idle(20);
        send_frame(9'h003, 8, 1, 1, -1, -1);
        idle(20);
        check_val("par1_done_cnt", done_cnt_b, 1);
        check_val("par1_data", data_b, 8'h03);
        check_val("par1_perr", perr_b, 1'b1);
        check_val("par1_ferr", ferr_b, 1'b0);
        send_frame(9'h003, 8, 0, 1, -1, -1);
        idle(20);
        check_val("par0_done_cnt", done_cnt_b, 2);
        check_val("par0_data", data_b, 8'h03);
        check_val("par0_perr", perr_b, 1'b0);

        // Break: 30 bit times low gives a single framed-error completion
        sel = 0;
        idle(20);
        rx = 1'b0;
        repeat (30 * BIT_T) @(negedge sclk_50M);
        idle(40);
        check_val("brk_done_cnt", done_cnt_a, 3);
        check_val("brk_data", data_a, 8'h00);
        check_val("brk_ferr", ferr_a, 1'b1);
        check_val("brk_perr", perr_a, 1'b0);
        send_frame(9'h05A, 8, -1, 1, -1, -1);
        idle(20);
        check_val("post_brk_done_cnt", done_cnt_a, 4);
        check_val("post_brk_data", data_a, 8'h5A);
        check_val("post_brk_ferr", ferr_a, 1'b0);

        // Back-to-back 8N2 frames with no idle gap
        sel = 2;
        idle(20);
        send_frame(9'h012, 8, -1, 2, -1, -1);
        send_frame(9'h034, 8, -1, 2, -1, -1);
        idle(20);
        check_val("b2b_done_cnt", done_cnt_c, 2);
        check_val("b2b_data0", c_data[0], 8'h12);
        check_val("b2b_data1", c_data[1], 8'h34);
        check_val("b2b_spacing", c_cyc[1] - c_cyc[0], 11 * BIT_T);
        check_val("b2b_ferr", ferr_c, 1'b0);

        // Reset in the middle of data bit 4; remaining bits of 0xF0 are high, no new edge
        sel = 0;
        idle(20);
        send_frame(9'h0F0, 8, -1, 1, -1, 4);
        idle(20);
        check_val("rst_mid_done_cnt", done_cnt_a, 4);
        check_val("rst_mid_data_cleared", data_a, 8'h00);
        send_frame(9'h07E, 8, -1, 1, -1, -1);
        idle(20);
        check_val("rst_7e_done_cnt", done_cnt_a, 5);
        check_val("rst_7e_data", data_a, 8'h7E);
        check_val("rst_7e_ferr", ferr_a, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
